// File: rtl/axis_packet_forwarder.sv
// rtl/axis_packet_forwarder.sv - drains a filtered packet from the forwarder read port onto an AXI-Stream master
`timescale 1ns/1ps
module axis_packet_forwarder #(
  parameter int SNOOP_FWD_ADDR_WIDTH = 9,
  parameter int DATA_WIDTH           = 64,
  parameter int PLEN_WIDTH           = 10
) (
  input  logic                            axi_aclk,
  input  logic                            axi_aresetn,
  input  logic                            ready_for_forwarder,
  input  logic [PLEN_WIDTH-1:0]           len_to_forwarder,
  output logic [SNOOP_FWD_ADDR_WIDTH-1:0] forwarder_rd_addr,
  output logic                            forwarder_rd_en,
  input  logic [DATA_WIDTH-1:0]           forwarder_rd_data,
  output logic                            forwarder_done,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready
);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  localparam logic [PLEN_WIDTH-1:0] MAX_LEN = PLEN_WIDTH'(1) << SNOOP_FWD_ADDR_WIDTH;

  state_t                  state, state_next;
  logic [PLEN_WIDTH-1:0]   len_q, rd_ptr, tx_cnt;
  logic [DATA_WIDTH-1:0]   entry0, entry1;
  logic [1:0]              count, occ;
  logic                    inflight, hold, pop, push, accept;

  assign pop    = m_axis_tvalid & m_axis_tready;
  assign push   = inflight;
  assign accept = (state == IDLE) && ready_for_forwarder && !hold;
  // Words held = buffered + in flight; a same-cycle pop frees a slot.
  assign occ    = count + {1'b0, inflight};

  assign forwarder_rd_en   = (state == STREAM) && (rd_ptr < len_q) &&
                             ((occ - {1'b0, pop}) < 2'd2);
  assign forwarder_rd_addr = rd_ptr[SNOOP_FWD_ADDR_WIDTH-1:0];
  assign forwarder_done    = (state == DONE);
  assign m_axis_tvalid     = (count != 2'd0);
  assign m_axis_tdata      = entry0;
  assign m_axis_tlast      = m_axis_tvalid && (tx_cnt == len_q - PLEN_WIDTH'(1));

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) state <= IDLE;
    else              state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = STREAM;
      STREAM:  if ((len_q == '0) || (pop && m_axis_tlast)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      len_q    <= '0;
      rd_ptr   <= '0;
      tx_cnt   <= '0;
      inflight <= 1'b0;
      hold     <= 1'b0;
      count    <= 2'd0;
      entry0   <= '0;
      entry1   <= '0;
    end else begin
      // One blind cycle after DONE lets the filter drop ready_for_forwarder.
      hold     <= (state == DONE);
      inflight <= forwarder_rd_en;
      if (accept) begin
        len_q  <= (len_to_forwarder > MAX_LEN) ? MAX_LEN : len_to_forwarder;
        rd_ptr <= '0;
        tx_cnt <= '0;
      end else begin
        if (forwarder_rd_en) rd_ptr <= rd_ptr + PLEN_WIDTH'(1);
        if (pop)             tx_cnt <= tx_cnt + PLEN_WIDTH'(1);
      end
      // entry0 is always the head; entry1 only holds data when count is 2.
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) entry0 <= forwarder_rd_data;
          else               entry1 <= forwarder_rd_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          entry0 <= entry1;
          count  <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            entry0 <= forwarder_rd_data;
          end else begin
            entry0 <= entry1;
            entry1 <= forwarder_rd_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_packet_forwarder.sv
// tb/tb_axis_packet_forwarder.sv - directed self-checking bench for axis_packet_forwarder
`timescale 1ns/1ps
module tb_axis_packet_forwarder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ready = 1'b0;
  logic [9:0]  len_in = '0;
  logic [8:0]  rd_addr;
  logic        rd_en;
  logic [63:0] rd_data = '0;
  logic        done;
  logic [63:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready = 1'b1;

  logic [63:0] mem [512];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  logic [63:0] bd_q[$];
  bit          bl_q[$];
  int          bc_q[$];
  int          ra_q[$];
  int          rc_q[$];
  int          nreads, npops, max_out, done_cnt, done_cyc, valid_cnt, stall_err;
  bit          prev_stall;
  logic [63:0] prev_data;
  logic        prev_last;
  bit          pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  axis_packet_forwarder dut (
    .axi_aclk            (clk),
    .axi_aresetn         (rst_n),
    .ready_for_forwarder (ready),
    .len_to_forwarder    (len_in),
    .forwarder_rd_addr   (rd_addr),
    .forwarder_rd_en     (rd_en),
    .forwarder_rd_data   (rd_data),
    .forwarder_done      (done),
    .m_axis_tdata        (tdata),
    .m_axis_tvalid       (tvalid),
    .m_axis_tlast        (tlast),
    .m_axis_tready       (tready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (rd_en) begin
        ra_q.push_back(int'(rd_addr));
        rc_q.push_back(cyc);
        nreads++;
      end
      if (tvalid) valid_cnt++;
      if (tvalid && tready) begin
        bd_q.push_back(tdata);
        bl_q.push_back(tlast);
        bc_q.push_back(cyc);
        npops++;
      end
      if (nreads - npops > max_out) max_out = nreads - npops;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (prev_stall && (!tvalid || tdata !== prev_data || tlast !== prev_last)) stall_err++;
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    bd_q.delete(); bl_q.delete(); bc_q.delete(); ra_q.delete(); rc_q.delete();
    nreads = 0; npops = 0; max_out = 0; done_cnt = 0; done_cyc = -1;
    valid_cnt = 0; stall_err = 0;
  endtask

  task automatic wait_done(input int n, input bit bp, input string tag);
    for (int i = 0; i < 3000 && done_cnt < n; i++) begin
      @(posedge clk); #1;
      tready = bp ? pat[cyc % 4] : 1'b1;
    end
    check({tag, "_timeout"}, 64'(done_cnt >= n), 64'd1);
  endtask

  task automatic run_pkt(input int len, input bit bp, input string tag, output int start);
    clear_log();
    @(posedge clk); #1;
    ready  = 1'b1;
    len_in = 10'(len);
    tready = bp ? pat[cyc % 4] : 1'b1;
    start  = cyc;
    wait_done(1, bp, tag);
    ready  = 1'b0;
    tready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_beats(input string tag, input int len);
    int bad;
    bad = 0;
    check({tag, "_beats"}, 64'(bd_q.size()), 64'(len));
    check({tag, "_reads"}, 64'(ra_q.size()), 64'(len));
    for (int i = 0; i < bd_q.size(); i++) begin
      if (bd_q[i] !== mem[i] || bl_q[i] !== (i == len - 1)) bad++;
    end
    for (int i = 0; i < ra_q.size(); i++) if (ra_q[i] != i) bad++;
    check({tag, "_order"}, 64'(bad), 64'd0);
    check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
  endtask

  initial begin
    int r, d1;
    clear_log();
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 64'(tvalid), 64'd0);
    check("rst_rd_en", 64'(rd_en), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_tlast", 64'(tlast), 64'd0);
    check("rst_tdata", tdata, 64'd0);
    check("rst_addr", 64'(rd_addr), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 4; i++) mem[i] = 64'hA0 + 64'(i);
    run_pkt(4, 1'b0, "basic", r);
    check_beats("basic", 4);
    for (int i = 0; i < 4 && i < bc_q.size(); i++) begin
      check($sformatf("basic_beat_cyc%0d", i), 64'(bc_q[i]), 64'(r + 3 + i));
      check($sformatf("basic_rd_cyc%0d", i), 64'(rc_q[i]), 64'(r + 1 + i));
    end
    if (bc_q.size() == 4) check("basic_done_cyc", 64'(done_cyc), 64'(bc_q[3] + 1));

    for (int i = 0; i < 6; i++) mem[i] = 64'hB0 + 64'(i);
    run_pkt(6, 1'b1, "bp", r);
    check_beats("bp", 6);
    check("bp_stall_stable", 64'(stall_err), 64'd0);
    check("bp_outstanding", 64'(max_out <= 2), 64'd1);

    run_pkt(0, 1'b0, "zero", r);
    check("zero_reads", 64'(nreads), 64'd0);
    check("zero_tvalid", 64'(valid_cnt), 64'd0);
    check("zero_done_cnt", 64'(done_cnt), 64'd1);
    check("zero_done_cyc", 64'(done_cyc), 64'(r + 2));

    for (int i = 0; i < 512; i++) mem[i] = {32'hD00D0000 | 32'(i), 32'(i * 7)};
    run_pkt(512, 1'b0, "max", r);
    check_beats("max", 512);
    run_pkt(700, 1'b0, "clamp", r);
    check_beats("clamp", 512);

    for (int i = 0; i < 3; i++) mem[i] = 64'hC0 + 64'(i);
    clear_log();
    @(posedge clk); #1;
    ready  = 1'b1;
    len_in = 10'd3;
    wait_done(1, 1'b0, "b2b_first");
    d1     = done_cyc;
    len_in = 10'd2;
    wait_done(2, 1'b0, "b2b_second");
    ready  = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("b2b_beats", 64'(bd_q.size()), 64'd5);
    check("b2b_done_cnt", 64'(done_cnt), 64'd2);
    if (bd_q.size() == 5) begin
      check("b2b_data", {bd_q[2][31:0], bd_q[4][31:0]}, {32'hC2, 32'hC1});
      check("b2b_tlast", 64'({bl_q[0], bl_q[1], bl_q[2], bl_q[3], bl_q[4]}), 64'b00101);
    end
    if (rc_q.size() == 5) check("b2b_restart_cyc", 64'(rc_q[3]), 64'(d1 + 3));

    for (int i = 0; i < 8; i++) mem[i] = 64'hE0 + 64'(i);
    clear_log();
    @(posedge clk); #1;
    ready  = 1'b1;
    len_in = 10'd8;
    for (int i = 0; i < 100 && npops < 2; i++) begin
      @(negedge clk); #1;
    end
    check("mid_two_beats", 64'(npops), 64'd2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tvalid", 64'(tvalid), 64'd0);
    check("mid_rst_rd_en", 64'(rd_en), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("mid_no_done", 64'(done_cnt), 64'd0);
    run_pkt(2, 1'b0, "after_rst", r);
    check_beats("after_rst", 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
